// File: rtl/user_ip_apb_bridge_if.sv
// APB4 bundle between the SoC crossbar and the user IP bridge.
// The bridge plugs into the slave modport.
interface apb4_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/user_ip_apb_bridge.sv
// Registered APB4 bridge fanning one crossbar port out to NUM_SLOT user IP slots.
// Define USER_IP_APB_TIMEOUT_EN to abort transfers whose slot never raises pready.
module user_ip_apb_bridge #(
    parameter int NUM_SLOT    = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    apb4_if.slave                    apb,
    output logic [NUM_SLOT-1:0]      user_psel_o,
    output logic                     user_penable_o,
    output logic                     user_pwrite_o,
    output logic [31:0]              user_paddr_o,
    output logic [31:0]              user_pwdata_o,
    output logic [3:0]               user_pstrb_o,
    output logic [2:0]               user_pprot_o,
    input  logic [NUM_SLOT*32-1:0]   user_prdata_i,
    input  logic [NUM_SLOT-1:0]      user_pready_i,
    input  logic [NUM_SLOT-1:0]      user_pslverr_i
);

    if (NUM_SLOT < 1 || NUM_SLOT > 16) begin : g_bad_num_slot
        $error("NUM_SLOT out of range");
    end
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam logic [4:0] SLOT_LIM = 5'(NUM_SLOT);

    state_t              state_q;
    logic [3:0]          slot_q;
    logic                pready_q;
    logic [31:0]         prdata_q;
    logic                pslverr_q;

    logic [3:0]          cap_idx;
    logic                cap_bad;
    logic [NUM_SLOT-1:0] cap_sel;
    logic [31:0]         sel_rdata;
    logic                sel_ready;
    logic                sel_err;

`ifdef USER_IP_APB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0]         to_cnt_q;
`endif

    assign apb.pready  = pready_q;
    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;

    always_comb begin
        cap_idx = apb.paddr[11:8];
        cap_bad = {1'b0, cap_idx} >= SLOT_LIM;
        cap_sel = '0;
        for (int k = 0; k < NUM_SLOT; k++) begin
            if (cap_idx == 4'(k)) cap_sel[k] = 1'b1;
        end
    end

    // Explicit per-slot mux so X on unselected slots never leaks through.
    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int k = 0; k < NUM_SLOT; k++) begin
            if (slot_q == 4'(k)) begin
                sel_rdata = user_prdata_i[k*32 +: 32];
                sel_ready = user_pready_i[k];
                sel_err   = user_pslverr_i[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= IDLE;
            slot_q         <= '0;
            pready_q       <= 1'b0;
            prdata_q       <= '0;
            pslverr_q      <= 1'b0;
            user_psel_o    <= '0;
            user_penable_o <= 1'b0;
            user_pwrite_o  <= 1'b0;
            user_paddr_o   <= '0;
            user_pwdata_o  <= '0;
            user_pstrb_o   <= '0;
            user_pprot_o   <= '0;
`ifdef USER_IP_APB_TIMEOUT_EN
            to_cnt_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (apb.psel && apb.penable) begin
                        slot_q        <= cap_idx;
                        user_pwrite_o <= apb.pwrite;
                        user_paddr_o  <= apb.paddr;
                        user_pwdata_o <= apb.pwdata;
                        user_pstrb_o  <= apb.pstrb;
                        user_pprot_o  <= apb.pprot;
                        if (cap_bad) begin
                            state_q   <= RESP;
                            pready_q  <= 1'b1;
                            prdata_q  <= '0;
                            pslverr_q <= 1'b1;
                        end else begin
                            state_q     <= SETUP;
                            user_psel_o <= cap_sel;
                        end
                    end
                end
                SETUP: begin
                    state_q        <= ACCESS;
                    user_penable_o <= 1'b1;
`ifdef USER_IP_APB_TIMEOUT_EN
                    to_cnt_q       <= '0;
`endif
                end
                ACCESS: begin
                    if (sel_ready) begin
                        state_q        <= RESP;
                        user_psel_o    <= '0;
                        user_penable_o <= 1'b0;
                        pready_q       <= 1'b1;
                        prdata_q       <= user_pwrite_o ? 32'd0 : sel_rdata;
                        pslverr_q      <= sel_err;
                    end
`ifdef USER_IP_APB_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        state_q        <= RESP;
                        user_psel_o    <= '0;
                        user_penable_o <= 1'b0;
                        pready_q       <= 1'b1;
                        prdata_q       <= '0;
                        pslverr_q      <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
`endif
                end
                RESP: begin
                    state_q   <= IDLE;
                    pready_q  <= 1'b0;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/user_ip_apb_bridge.md
# user_ip_apb_bridge

Registered APB4 bridge that sits directly upstream of the user IP slots. It takes one APB4 slave port from the SoC peripheral crossbar and decodes the slot index from the address. It re-issues each transfer as a clean setup/access sequence on one of NUM_SLOT downstream user-IP APB ports, then returns the captured read data and error status upstream. An optional watchdog aborts transfers whose slot never asserts pready.

## Interface
Parameters:
- NUM_SLOT, 4: number of user IP slots, legal range 1..16.
- TIMEOUT_CYC, 255: maximum number of downstream ACCESS cycles before abort; legal range 2..65535.

Ports:
- clk_i  input  1  system clock; all logic is rising-edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- apb  apb4_if.slave  —  upstream port from the crossbar; uses psel, penable, pwrite, paddr[31:0], pwdata[31:0], pstrb[3:0], pprot[2:0], prdata[31:0], pready, pslverr.
- user_psel_o  output  NUM_SLOT  one-hot downstream select.
- user_penable_o  output  1  downstream enable.
- user_pwrite_o  output  1  registered pwrite.
- user_paddr_o  output  32  registered paddr, passed unmodified; a slot decodes [7:0].
- user_pwdata_o  output  32  registered pwdata.
- user_pstrb_o  output  4  registered pstrb.
- user_pprot_o  output  3  registered pprot.
- user_prdata_i  input  NUM_SLOT*32  slot k read data at bits [32k+31:32k].
- user_pready_i  input  NUM_SLOT  per-slot pready.
- user_pslverr_i  input  NUM_SLOT  per-slot pslverr.

## Operation
- Slot index is paddr[11:8].
- A slot index of NUM_SLOT or greater is a decode error.
- FSM states are IDLE, SETUP, ACCESS and RESP.
- IDLE:
  - On apb.psel && apb.penable, register paddr, pwrite, pwdata, pstrb and pprot, plus the slot index.
  - Valid slot: go to SETUP.
  - Decode error: go to RESP with error=1 and rdata=0; no downstream psel is asserted.
- SETUP: user_psel_o[slot]=1, user_penable_o=0. Always goes to ACCESS next cycle.
- ACCESS: user_psel_o[slot]=1, user_penable_o=1.
  - When user_pready_i[slot]=1: capture rdata (user_prdata_i slice if the transfer is a read, else 0) and user_pslverr_i[slot], then go to RESP.
- RESP:
  - apb.pready=1; apb.prdata and apb.pslverr come from the captured registers.
  - Always returns to IDLE next cycle.
- apb.pready=0 in IDLE, SETUP and ACCESS.
- apb.prdata=0 and apb.pslverr=0 outside RESP.
- user_pwrite_o, user_paddr_o, user_pwdata_o, user_pstrb_o and user_pprot_o hold their registered values from capture until the next capture.
- Only user_prdata_i, user_pready_i and user_pslverr_i of the selected slot are observed. Other slots' inputs are ignored, including X.
- Reset values: all outputs 0; FSM=IDLE; timeout counter=0; captured registers=0.
- Reset asserted mid-transfer: outputs go to 0 asynchronously and the FSM goes to IDLE. The upstream transfer is dropped; the master must re-issue it.

## Timing
- Minimum upstream access-phase length is 4 cycles:
  - c0: IDLE captures.
  - c1: SETUP.
  - c2: ACCESS with slot pready=1.
  - c3: RESP with apb.pready=1.
- Each downstream wait cycle adds 1 cycle.
- Decode-error latency is 2 cycles: c0 IDLE, c1 RESP.
- An upstream setup phase (psel=1, penable=0) is ignored.
- The cycle after RESP is always IDLE. Back-to-back transfers therefore have at least one IDLE cycle, which coincides with the upstream setup phase.
- user_psel_o is never asserted in two consecutive transfers without an intervening cycle of 0.

## Configuration
- USER_IP_APB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - If pready is still 0 when the counter equals TIMEOUT_CYC-1, the next cycle is RESP with pslverr=1 and prdata=0, and user_psel_o/user_penable_o drop to 0.
  - pready=1 on the terminal cycle wins over timeout: a normal completion.
- USER_IP_APB_TIMEOUT_EN undefined: no counter is instantiated, and ACCESS waits indefinitely for pready.

## Test plan
- Read slot 1 at paddr=0x0000_0100, slot 1 pready=1, prdata=0x0000_0005 -> user_psel_o=4'b0010 for exactly 2 cycles (SETUP, ACCESS); apb.pready high in c3; apb.prdata=0x5; pslverr=0.
- Write paddr=0x0000_0304, pwdata=0xA5A5_5A5A, pstrb=4'hF, slot 3 pready delayed 3 cycles -> user_pwdata_o=0xA5A5_5A5A and user_pwrite_o=1 during SETUP/ACCESS; apb.pready in c6; prdata=0.
- paddr=0x0000_0500 with NUM_SLOT=4 -> user_psel_o stays 0; apb.pready=1 in c1 with pslverr=1, prdata=0.
- Slot 2 returns pslverr=1 with pready=1 -> apb.pslverr=1 in RESP; the next transfer to slot 0 completes with pslverr=0.
- With USER_IP_APB_TIMEOUT_EN and TIMEOUT_CYC=8, slot 0 pready stuck at 0 -> ACCESS lasts exactly 8 cycles, then RESP with pslverr=1, prdata=0; user_psel_o=0 in RESP.
- rst_n_i pulsed low during ACCESS -> all outputs 0 in the same cycle; after release the FSM is IDLE, and a new read of slot 0 completes in 4 cycles.
